// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control sequencer.
// Holds the FSM state enum, opcode/funct values, the datapath select encodings,
// and the ID-stage dispatch helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EX_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_EX_M   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_LW  = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12,
        S_ILL    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [1:0] PCS_INC = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    localparam logic [1:0] WRS_RT = 2'b00;
    localparam logic [1:0] WRS_RD = 2'b01;
    localparam logic [1:0] WRS_RA = 2'b10;

    localparam logic [1:0] WDS_ALU = 2'b00;
    localparam logic [1:0] WDS_MEM = 2'b01;
    localparam logic [1:0] WDS_PC  = 2'b10;

    // Dispatch from ID: which execute-class state an instruction enters.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_e nxt;
        nxt = S_ILL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLLV: nxt = S_EX_R;
                    default:                         nxt = S_ILL;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EX_I;
            OP_LW, OP_SW:                               nxt = S_EX_M;
            OP_BEQ, OP_BNE:                             nxt = S_BR;
            OP_J, OP_JAL:                               nxt = S_JMP;
            default:                                    nxt = S_ILL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: bundle between the IR/ALU flags and the datapath controls.
// There is no valid/ready pair here: run is a level request sampled only at
// instruction boundaries, Inst_code/ZF/OF are held stable by the datapath
// while an instruction is in flight, and every control output is Moore.
interface mips_mc_ctrl_if #(
    parameter int STATE_W = 4
);
    logic               run;
    logic [31:0]        Inst_code;
    logic               ZF;
    logic               OF;
    logic               PC_Write;
    logic [1:0]         PC_s;
    logic               IR_Write;
    logic               Mem_Write;
    logic               Write_Reg;
    logic [1:0]         w_r_s;
    logic [1:0]         wr_data_s;
    logic               imm_s;
    logic               rt_imm_s;
    logic [2:0]         ALU_OP;
    logic               illegal;
    logic               ovf;
    logic [31:0]        retired;
    logic [STATE_W-1:0] dbg_state;

    // Datapath side: supplies instruction and flags, consumes controls.
    modport master (
        output run, Inst_code, ZF, OF,
        input  PC_Write, PC_s, IR_Write, Mem_Write, Write_Reg, w_r_s, wr_data_s,
               imm_s, rt_imm_s, ALU_OP, illegal, ovf, retired, dbg_state
    );

    // Controller side.
    modport slave (
        input  run, Inst_code, ZF, OF,
        output PC_Write, PC_s, IR_Write, Mem_Write, Write_Reg, w_r_s, wr_data_s,
               imm_s, rt_imm_s, ALU_OP, illegal, ovf, retired, dbg_state
    );
endinterface

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: combinational opcode/funct -> ALU_OP and immediate-extension decode.
// Shared by the R-type execute, I-type execute and branch-compare states.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       imm_s_o
);

    // Table lookup; unsupported codes fall back to ADD with zero-extension.
    always_comb begin
        alu_op_o = ALU_ADD;
        imm_s_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_XOR:  alu_op_o = ALU_XOR;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLLV: alu_op_o = ALU_SLL;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            OP_ADDI:        begin alu_op_o = ALU_ADD; imm_s_o = 1'b1; end
            OP_SLTI:        begin alu_op_o = ALU_SLT; imm_s_o = 1'b1; end
            OP_ANDI:        alu_op_o = ALU_AND;
            OP_ORI:         alu_op_o = ALU_OR;
            OP_XORI:        alu_op_o = ALU_XOR;
            OP_BEQ, OP_BNE: begin alu_op_o = ALU_SUB; imm_s_o = 1'b1; end
            OP_LW, OP_SW:   begin alu_op_o = ALU_ADD; imm_s_o = 1'b1; end
            default:        ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control sequencer for the MIPS R/I/J datapath.
// Walks each instruction through IF/ID/EX/MEM/WB on a single clock and drives
// every datapath enable and select as a Moore function of state + Inst_code.
// Optional macro MIPS_CTRL_RETIRE_CNT_EN: when defined, `retired` counts
// retired instructions; when undefined it is tied to zero with no flops.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit OVF_SUPPRESS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mips_mc_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    logic       illegal_q, ovf_q;
    logic [5:0] opcode, funct;
    logic [2:0] dec_alu_op;
    logic       dec_imm_s;
    logic       retire_st, is_addsub_r, is_addi, ovf_hit;
    logic       pc_write, ir_write, mem_write, write_reg, imm_s, rt_imm_s;
    logic [1:0] pc_s, w_r_s, wr_data_s;
    logic [2:0] alu_op;

    assign opcode = bus.Inst_code[31:26];
    assign funct  = bus.Inst_code[5:0];

    mips_alu_dec u_alu_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .alu_op_o (dec_alu_op),
        .imm_s_o  (dec_imm_s)
    );

    // States whose exit completes an instruction.
    assign retire_st = (state_q inside {S_MEM_WR, S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP});

    // Signed-overflow write suppression only applies to add/sub/addi.
    assign is_addsub_r = (opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB));
    assign is_addi     = (opcode == OP_ADDI);
    assign ovf_hit     = OVF_SUPPRESS && bus.OF &&
                         (((state_q == S_WB_R) && is_addsub_r) ||
                          ((state_q == S_WB_I) && is_addi));

    // State register; reset parks the sequencer in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Sticky status: illegal is raised on entry to ILL, ovf when a write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            illegal_q <= illegal_q | (state_d == S_ILL);
            ovf_q     <= ovf_q | ovf_hit;
        end
    end

    // Next-state and Moore control outputs.
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_s      = PCS_INC;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        write_reg = 1'b0;
        w_r_s     = WRS_RT;
        wr_data_s = WDS_ALU;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        alu_op    = ALU_ADD;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_IF;
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_ID;
            end
            S_ID:     state_d = decode_next(opcode, funct);
            S_EX_R: begin
                alu_op  = dec_alu_op;
                state_d = S_WB_R;
            end
            S_EX_I: begin
                rt_imm_s = 1'b1;
                imm_s    = dec_imm_s;
                alu_op   = dec_alu_op;
                state_d  = S_WB_I;
            end
            S_EX_M: begin
                rt_imm_s = 1'b1;
                imm_s    = 1'b1;
                alu_op   = ALU_ADD;
                state_d  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: state_d = S_WB_LW;
            S_MEM_WR: mem_write = 1'b1;
            S_WB_R: begin
                write_reg = ~ovf_hit;
                w_r_s     = WRS_RD;
            end
            S_WB_I:   write_reg = ~ovf_hit;
            S_WB_LW: begin
                write_reg = 1'b1;
                wr_data_s = WDS_MEM;
            end
            S_BR: begin
                alu_op   = dec_alu_op;
                imm_s    = dec_imm_s;
                pc_s     = PCS_BR;
                pc_write = (opcode == OP_BEQ) ? bus.ZF : ~bus.ZF;
            end
            S_JMP: begin
                pc_write = 1'b1;
                pc_s     = PCS_JMP;
                if (opcode == OP_JAL) begin
                    write_reg = 1'b1;
                    w_r_s     = WRS_RA;
                    wr_data_s = WDS_PC;
                end
            end
            S_ILL:    state_d = S_ILL;
            default:  state_d = S_IDLE;
        endcase
        if (retire_st) state_d = bus.run ? S_IF : S_IDLE;
    end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           retired_q <= 32'd0;
        else if (retire_st) retired_q <= retired_q + 32'd1;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = 32'd0;
`endif

    assign bus.PC_Write  = pc_write;
    assign bus.PC_s      = pc_s;
    assign bus.IR_Write  = ir_write;
    assign bus.Mem_Write = mem_write;
    assign bus.Write_Reg = write_reg;
    assign bus.w_r_s     = w_r_s;
    assign bus.wr_data_s = wr_data_s;
    assign bus.imm_s     = imm_s;
    assign bus.rt_imm_s  = rt_imm_s;
    assign bus.ALU_OP    = alu_op;
    assign bus.illegal   = illegal_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: bench for mips_mc_ctrl. Directed cases plus random
// instruction streams checked against a per-instruction transaction model.
module tb_mips_mc_ctrl;
    import mips_ctrl_pkg::*;

    localparam int STATE_W      = 4;
    localparam bit OVF_SUPPRESS = 1'b1;

    logic clk;
    logic rst;

    mips_mc_ctrl_if #(.STATE_W(STATE_W)) bus ();

    mips_mc_ctrl #(.STATE_W(STATE_W), .OVF_SUPPRESS(OVF_SUPPRESS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic        ovf_m;
    logic [31:0] ret_m;

    // Expected summary of one instruction, as seen on the control outputs.
    typedef struct packed {
        logic [3:0] lat;
        logic [3:0] ir;
        logic [3:0] pcw;
        logic [3:0] wr;
        logic [3:0] mw;
        logic [1:0] pcs;
        logic [1:0] wrs;
        logic [1:0] wds;
        logic [2:0] alu;
        logic       rt;
        logic       imm;
        logic       chk_alu;
        logic       chk_imm;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Whole-instruction view: latency, how many cycles each enable is high,
    // the select values seen when they are, and the EX-cycle ALU controls.
    function automatic exp_t model(input logic [31:0] ins, input logic zf, input logic of_in);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        logic taken;
        e = '0;
        op = ins[31:26];
        fn = ins[5:0];
        e.ir  = 4'd1;
        e.pcw = 4'd1;
        e.lat = 4'd4;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: e.alu = 3'b100;
                    6'h22: e.alu = 3'b101;
                    6'h24: e.alu = 3'b000;
                    6'h25: e.alu = 3'b001;
                    6'h26: e.alu = 3'b010;
                    6'h27: e.alu = 3'b011;
                    6'h2a: e.alu = 3'b110;
                    default: e.alu = 3'b111;
                endcase
                e.chk_alu = 1'b1;
                e.ovf = OVF_SUPPRESS && of_in && (fn == 6'h20 || fn == 6'h22);
                e.wr  = e.ovf ? 4'd0 : 4'd1;
                e.wrs = e.ovf ? 2'd0 : 2'd1;
            end
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: begin
                case (op)
                    6'h08:   begin e.alu = 3'b100; e.imm = 1'b1; end
                    6'h0a:   begin e.alu = 3'b110; e.imm = 1'b1; end
                    6'h0c:   e.alu = 3'b000;
                    6'h0d:   e.alu = 3'b001;
                    default: e.alu = 3'b010;
                endcase
                e.rt = 1'b1;
                e.chk_alu = 1'b1;
                e.chk_imm = 1'b1;
                e.ovf = OVF_SUPPRESS && of_in && (op == 6'h08);
                e.wr  = e.ovf ? 4'd0 : 4'd1;
            end
            6'h23: begin
                e.lat = 4'd5;
                e.alu = 3'b100; e.rt = 1'b1; e.imm = 1'b1;
                e.chk_alu = 1'b1; e.chk_imm = 1'b1;
                e.wr = 4'd1; e.wds = 2'd1;
            end
            6'h2b: begin
                e.alu = 3'b100; e.rt = 1'b1; e.imm = 1'b1;
                e.chk_alu = 1'b1; e.chk_imm = 1'b1;
                e.mw = 4'd1;
            end
            6'h04, 6'h05: begin
                e.lat = 4'd3;
                e.alu = 3'b101; e.imm = 1'b1;
                e.chk_alu = 1'b1; e.chk_imm = 1'b1;
                taken = (op == 6'h04) ? zf : ~zf;
                e.pcw = taken ? 4'd2 : 4'd1;
                e.pcs = taken ? 2'd1 : 2'd0;
            end
            default: begin
                e.lat = 4'd3;
                e.pcw = 4'd2;
                e.pcs = 2'd2;
                if (op == 6'h03) begin
                    e.wr = 4'd1; e.wrs = 2'd2; e.wds = 2'd2;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom();
        k = $urandom_range(0, 18);
        case (k)
            0:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h20; end
            1:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h22; end
            2:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h24; end
            3:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h25; end
            4:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h26; end
            5:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h27; end
            6:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h2a; end
            7:  begin ins[31:26] = 6'h00; ins[5:0] = 6'h04; end
            8:  ins[31:26] = 6'h08;
            9:  ins[31:26] = 6'h0a;
            10: ins[31:26] = 6'h0c;
            11: ins[31:26] = 6'h0d;
            12: ins[31:26] = 6'h0e;
            13: ins[31:26] = 6'h23;
            14: ins[31:26] = 6'h2b;
            15: ins[31:26] = 6'h04;
            16: ins[31:26] = 6'h05;
            17: ins[31:26] = 6'h02;
            default: ins[31:26] = 6'h03;
        endcase
        return ins;
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Called with the DUT in IF; returns with the DUT in IF of the next instruction.
    task automatic run_instr(input logic [31:0] ins, input logic zf, input logic of_in);
        exp_t e;
        exp_t o;
        int cyc;
        bit done;
        exp_q.push_back(model(ins, zf, of_in));
        bus.Inst_code = ins;
        bus.ZF = zf;
        bus.OF = of_in;
        #1;
        o = '0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 8) begin
            if (bus.IR_Write) o.ir = o.ir + 4'd1;
            if (bus.PC_Write) begin
                o.pcw = o.pcw + 4'd1;
                if (cyc > 0) o.pcs = bus.PC_s;
            end
            if (bus.Write_Reg) begin
                o.wr  = o.wr + 4'd1;
                o.wrs = bus.w_r_s;
                o.wds = bus.wr_data_s;
            end
            if (bus.Mem_Write) o.mw = o.mw + 4'd1;
            if (cyc == 2) begin
                o.alu = bus.ALU_OP;
                o.rt  = bus.rt_imm_s;
                o.imm = bus.imm_s;
            end
            tick();
            cyc++;
            if (bus.dbg_state == STATE_W'(S_IF)) done = 1'b1;
        end
        o.lat = done ? 4'(cyc) : 4'hF;
        e = exp_q.pop_front();
        check_val("latency",   32'(o.lat), 32'(e.lat));
        check_val("ir_write",  32'(o.ir),  32'(e.ir));
        check_val("pc_write",  32'(o.pcw), 32'(e.pcw));
        check_val("pc_s",      32'(o.pcs), 32'(e.pcs));
        check_val("write_reg", 32'(o.wr),  32'(e.wr));
        check_val("w_r_s",     32'(o.wrs), 32'(e.wrs));
        check_val("wr_data_s", 32'(o.wds), 32'(e.wds));
        check_val("mem_write", 32'(o.mw),  32'(e.mw));
        if (e.chk_alu) begin
            check_val("alu_op",   32'(o.alu), 32'(e.alu));
            check_val("rt_imm_s", 32'(o.rt),  32'(e.rt));
        end
        if (e.chk_imm) check_val("imm_s", 32'(o.imm), 32'(e.imm));
        ovf_m = ovf_m | e.ovf;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        ret_m = ret_m + 32'd1;
`endif
        check_val("ovf",     32'(bus.ovf), 32'(ovf_m));
        check_val("retired", bus.retired,  ret_m);
        check_val("illegal", 32'(bus.illegal), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_state"}, 32'(bus.dbg_state), 32'(S_IDLE));
        check_val({tag, "_en"}, 32'({bus.PC_Write, bus.IR_Write, bus.Mem_Write, bus.Write_Reg}), 32'd0);
        check_val({tag, "_sel"}, 32'({bus.PC_s, bus.w_r_s, bus.wr_data_s, bus.imm_s, bus.rt_imm_s}), 32'd0);
        check_val({tag, "_alu"}, 32'(bus.ALU_OP), 32'h4);
        check_val({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        check_val({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check_val({tag, "_retired"}, bus.retired, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        ovf_m = 1'b0;
        ret_m = 32'd0;
        rst = 1'b0;
        bus.run = 1'b0;
        bus.Inst_code = 32'd0;
        bus.ZF = 1'b0;
        bus.OF = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");

        rst = 1'b1;
        tick();
        tick();
        check_val("idle_hold", 32'(bus.dbg_state), 32'(S_IDLE));
        bus.run = 1'b1;
        tick();
        check_val("idle_to_if", 32'(bus.dbg_state), 32'(S_IF));

        // Directed instructions.
        run_instr(32'h00221820, 1'b0, 1'b0);  // add
        run_instr(32'h8C050008, 1'b0, 1'b0);  // lw
        run_instr(32'hAC050008, 1'b0, 1'b0);  // sw
        run_instr(32'h10220003, 1'b1, 1'b0);  // beq taken
        run_instr(32'h10220003, 1'b0, 1'b0);  // beq not taken
        run_instr(32'h14220003, 1'b1, 1'b0);  // bne not taken
        run_instr(32'h14220003, 1'b0, 1'b0);  // bne taken
        run_instr(32'h0C000010, 1'b0, 1'b0);  // jal
        run_instr(32'h08000010, 1'b0, 1'b0);  // j
        run_instr(32'h2822FFFF, 1'b0, 1'b1);  // slti with OF: write not suppressed
        run_instr(32'h00221820, 1'b0, 1'b1);  // add overflow: write suppressed
        run_instr(32'h00221822, 1'b0, 1'b1);  // sub overflow
        run_instr(32'h20220005, 1'b0, 1'b1);  // addi overflow

        // Random instruction stream.
        for (int i = 0; i < 250; i++) begin
            run_instr(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // run dropped in EX_R: instruction completes, then IDLE.
        bus.Inst_code = 32'h00221820;
        bus.OF = 1'b0;
        tick();
        tick();
        check_val("drop_ex_r", 32'(bus.dbg_state), 32'(S_EX_R));
        bus.run = 1'b0;
        tick();
        check_val("drop_wb_r", 32'(bus.dbg_state), 32'(S_WB_R));
        check_val("drop_wb_wr", 32'(bus.Write_Reg), 32'd1);
        tick();
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        ret_m = ret_m + 32'd1;
`endif
        check_val("drop_idle", 32'(bus.dbg_state), 32'(S_IDLE));
        check_val("drop_retired", bus.retired, ret_m);
        tick();
        check_val("drop_park", 32'(bus.dbg_state), 32'(S_IDLE));
        check_val("drop_no_fetch", 32'(bus.IR_Write), 32'd0);

        // Asynchronous reset in EX_M.
        bus.run = 1'b1;
        tick();
        bus.Inst_code = 32'h8C050008;
        tick();
        tick();
        check_val("rst_in_exm", 32'(bus.dbg_state), 32'(S_EX_M));
        #2;
        rst = 1'b0;
        #1;
        check_reset("async_rst");
        ovf_m = 1'b0;
        ret_m = 32'd0;
        tick();
        rst = 1'b1;
        tick();
        check_val("rst_refetch", 32'(bus.dbg_state), 32'(S_IF));

        // Unsupported opcode 0x3F: ILL held until reset.
        bus.Inst_code = 32'hFC000000;
        tick();
        tick();
        check_val("ill_state", 32'(bus.dbg_state), 32'(S_ILL));
        check_val("ill_flag", 32'(bus.illegal), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("ill_hold", 32'(bus.dbg_state), 32'(S_ILL));
            check_val("ill_en", 32'({bus.PC_Write, bus.IR_Write, bus.Mem_Write, bus.Write_Reg}), 32'd0);
        end
        check_val("ill_retired", bus.retired, ret_m);
        rst = 1'b0;
        #1;
        check_val("ill_clear_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check_val("ill_clear_flag", 32'(bus.illegal), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Unsupported R-type funct (000000) also lands in ILL.
        bus.Inst_code = 32'h00000000;
        tick();
        tick();
        check_val("ill_funct_state", 32'(bus.dbg_state), 32'(S_ILL));
        check_val("ill_funct_flag", 32'(bus.illegal), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS R/I/J datapath. It replaces the fixed dual-clock single-cycle scheme, where memory runs on a separate faster clock.
- Steps each instruction through IF/ID/EX/MEM/WB states on one clock.
- Decodes the IR output (Inst_code) and ALU flags.
- Drives every datapath write-enable and mux select.
- Sits between the IR/ALU flags and the datapath enables/selects inside CPU.

Parameters:
STATE_W, 4, width of dbg_state output (>=4).
OVF_SUPPRESS, 1, 1 = suppress register write on signed overflow of add/sub/addi; 0 = write anyway.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
run  in  1  1 = fetch next instruction; 0 = park in IDLE after the current instruction retires.
Inst_code  in  32  IR contents; valid from ID onward.
ZF  in  1  ALU zero flag.
OF  in  1  ALU signed overflow flag.
PC_Write  out  1  PC register load enable.
PC_s  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
IR_Write  out  1  IR load enable.
Mem_Write  out  1  data memory write enable.
Write_Reg  out  1  register file write enable.
w_r_s  out  2  write-register select: 00 rt, 01 rd, 10 $31.
wr_data_s  out  2  write-data select: 00 ALU F, 01 M_R_Data, 10 PC (link).
imm_s  out  1  1 sign-extend imm16, 0 zero-extend.
rt_imm_s  out  1  ALU B select: 0 R_Data_B, 1 extended imm.
ALU_OP  out  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLL.
illegal  out  1  sticky; unsupported opcode/funct seen.
ovf  out  1  sticky; overflow-suppressed write occurred.
retired  out  32  retired-instruction count (see Optional Feature).
dbg_state  out  STATE_W  current state encoding.

Behaviour:
- Outputs are Moore: a function of the state register plus Inst_code. No output depends on ZF/OF except PC_Write in BR and Write_Reg in WB.
- Reset (rst=0, async): state=IDLE; illegal=0, ovf=0, retired=0. All enables 0, selects 0, ALU_OP=100.
- States: IDLE, IF, ID, EX_R, EX_I, EX_M, MEM_RD, MEM_WR, WB_R, WB_I, WB_LW, BR, JMP, ILL.
- IDLE: all enables 0. Goes to IF when run=1.
- IF: IR_Write=1, PC_Write=1, PC_s=00. Goes to ID.
- ID: decode only, no enables. Next state by opcode:
  - 000000 with funct in {add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sllv 000100}: EX_R.
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110: EX_I.
  - lw 100011, sw 101011: EX_M.
  - beq 000100, bne 000101: BR.
  - j 000010, jal 000011: JMP.
  - anything else: ILL.
- EX_R: rt_imm_s=0, ALU_OP from funct. Goes to WB_R.
- EX_I: rt_imm_s=1. imm_s=1 for addi/slti, 0 for andi/ori/xori. ALU_OP from opcode. Goes to WB_I.
- EX_M: rt_imm_s=1, imm_s=1, ALU_OP=ADD. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: address held, no enables. Goes to WB_LW.
- MEM_WR: Mem_Write=1. Retires.
- WB_R: Write_Reg=1, w_r_s=01, wr_data_s=00. Retires.
- WB_I: Write_Reg=1, w_r_s=00, wr_data_s=00. Retires.
- WB_LW: Write_Reg=1, w_r_s=00, wr_data_s=01. Retires.
- Overflow (OVF_SUPPRESS=1): in WB_R for add/sub, or WB_I for addi, with OF=1 → Write_Reg=0 and ovf set. The instruction still retires.
- BR: ALU_OP=SUB, rt_imm_s=0, imm_s=1, PC_s=01. PC_Write = ZF for beq, ~ZF for bne. Retires.
- JMP: PC_Write=1, PC_s=10. For jal additionally Write_Reg=1, w_r_s=10, wr_data_s=10 (PC already +4). Retires.
- ILL: illegal=1, all enables 0. Holds until reset.
- "Retires" means: next state is IF if run=1, else IDLE, and retired increments by 1 (wraps 0xFFFFFFFF→0).
- Latency in cycles: R/I-ALU 4, lw 5, sw 4, beq/bne/j/jal 3.
- run falling mid-instruction: the current instruction completes; the FSM parks in IDLE.
- rst asserted in any state: immediate return to IDLE. No partial write is required to complete.
- Unused state encodings recover to IDLE on the next edge.

Optional Feature:
MIPS_CTRL_RETIRE_CNT_EN:
- Defined: the retired counter is implemented as above.
- Undefined: retired is tied to 32'd0 and no counter flops are inferred.
- The port exists in both cases.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum;
  - opcode/funct localparams;
  - ALU_OP, PC_s, w_r_s and wr_data_s encodings.
- One sub-module, mips_alu_dec: combinational opcode/funct → ALU_OP and imm_s decode. Reused by EX_R, EX_I and BR.

Test Plan:
- Reset, run=1, Inst_code=add $3,$1,$2 (0x00221820), OF=0 → states IDLE,IF,ID,EX_R,WB_R. Write_Reg=1 with w_r_s=01 in WB_R; retired=1.
- lw $5,8($0) (0x8C050008) → 5 states. Mem_Write never 1; WB_LW has wr_data_s=01, w_r_s=00. sw 0xAC050008 → MEM_WR has Mem_Write=1, 4 cycles.
- beq (0x10220003): ZF=1 → PC_Write=1, PC_s=01 in BR. ZF=0 → PC_Write=0. bne (0x14220003) gives the inverse.
- jal 0x0C000010 → JMP: PC_s=10, Write_Reg=1, w_r_s=10, wr_data_s=10; 3 cycles.
- add with OF=1 in WB_R → Write_Reg=0, ovf=1 (sticky), retired still increments. Opcode 0x3F → ILL, illegal=1; held until rst.
- run dropped in EX_R → WB_R completes, then IDLE. rst pulsed low in EX_M → IDLE asynchronously, all enables 0.
